// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot machine game controller.
package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPIN0 = 3'd1,
    ST_SPIN1 = 3'd2,
    ST_SPIN2 = 3'd3,
    ST_EVAL  = 3'd4,
    ST_PAY   = 3'd5
  } slot_state_t;

  localparam int PAY_TRIPLE_DFLT = 10;
  localparam int PAY_PAIR_DFLT   = 2;

  // Unsigned add clamped to max_val; the carry bit keeps overflow visible.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/slot_sequencer_edge_detect.sv
// Rising-edge detector for a level switch; the history flop resets high so a
// switch held through reset does not look like a fresh press.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/slot_sequencer.sv
// Three-reel slot machine controller: credit bookkeeping, reel release/freeze
// sequencing with auto-stop, scoring of the frozen symbols and payout.
module slot_sequencer
  import slot_pkg::*;
#(
  parameter int SYM_W      = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 99,
  parameter int BET        = 1,
  parameter int AUTO_STOP  = 8,
  parameter int PAY_TRIPLE = PAY_TRIPLE_DFLT,
  parameter int PAY_PAIR   = PAY_PAIR_DFLT
) (
  input  logic                clk_2,
  input  logic                reset_n,
  input  logic                coin,
  input  logic                start,
  input  logic                stop,
  input  logic [SYM_W-1:0]    reel0,
  input  logic [SYM_W-1:0]    reel1,
  input  logic [SYM_W-1:0]    reel2,
  output logic [2:0]          freeze,
  output logic                reels_clear,
  output logic [CREDIT_W-1:0] credits,
  output logic [CREDIT_W-1:0] payout,
  output logic                win,
  output logic [2:0]          state
);

  localparam int TIMER_W = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;

  logic coin_rise, start_rise, stop_rise;

  edge_detect u_coin_edge  (.clk_i(clk_2), .rst_ni(reset_n), .sig_i(coin),  .rise_o(coin_rise));
  edge_detect u_start_edge (.clk_i(clk_2), .rst_ni(reset_n), .sig_i(start), .rise_o(start_rise));
  edge_detect u_stop_edge  (.clk_i(clk_2), .rst_ni(reset_n), .sig_i(stop),  .rise_o(stop_rise));

  slot_state_t         state_q;
  logic [2:0]          freeze_q;
  logic                reels_clear_q;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CREDIT_W-1:0] payout_q;
  logic                win_q;
  logic [TIMER_W-1:0]  timer_q;

  logic                bet_take;
  logic                reel_stop;
  logic [CREDIT_W-1:0] score;
  logic [31:0]         base_sum;
  logic [31:0]         pay_add;

  assign bet_take  = (state_q == ST_IDLE) && start_rise && (credits_q >= CREDIT_W'(BET));
  assign reel_stop = stop_rise || (timer_q == TIMER_W'(AUTO_STOP - 1));

  always_comb begin
    score = '0;
    if ((reel0 == reel1) && (reel1 == reel2)) begin
      score = CREDIT_W'(PAY_TRIPLE);
    end else if ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2)) begin
      score = CREDIT_W'(PAY_PAIR);
    end
  end

  // Coin, bet and payout are summed first so saturation sees the net result.
  always_comb begin
    base_sum  = 32'(credits_q) + (coin_rise ? 32'd1 : 32'd0) - (bet_take ? 32'(BET) : 32'd0);
    pay_add   = (state_q == ST_PAY) ? 32'(payout_q) : 32'd0;
    credits_d = CREDIT_W'(sat_add(base_sum, pay_add, 32'(MAX_CREDIT)));
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      freeze_q      <= 3'b111;
      reels_clear_q <= 1'b0;
      credits_q     <= '0;
      payout_q      <= '0;
      win_q         <= 1'b0;
      timer_q       <= '0;
    end else begin
      credits_q     <= credits_d;
      reels_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bet_take) begin
            state_q       <= ST_SPIN0;
            freeze_q      <= 3'b000;
            reels_clear_q <= 1'b1;
            win_q         <= 1'b0;
            timer_q       <= '0;
          end
        end
        ST_SPIN0: begin
          if (reel_stop) begin
            freeze_q[0] <= 1'b1;
            state_q     <= ST_SPIN1;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_SPIN1: begin
          if (reel_stop) begin
            freeze_q[1] <= 1'b1;
            state_q     <= ST_SPIN2;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_SPIN2: begin
          if (reel_stop) begin
            freeze_q[2] <= 1'b1;
            state_q     <= ST_EVAL;
            timer_q     <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        // All reels are frozen here, so the sampled symbols are stable.
        ST_EVAL: begin
          payout_q <= score;
          state_q  <= ST_PAY;
        end
        ST_PAY: begin
          win_q   <= (payout_q != '0);
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign freeze      = freeze_q;
  assign reels_clear = reels_clear_q;
  assign credits     = credits_q;
  assign payout      = payout_q;
  assign win         = win_q;
  assign state       = state_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// Bench for slot_sequencer: directed game scenarios plus random switch/reel
// activity, all outputs compared each cycle against a game-level model.
module tb_slot_sequencer;
  import slot_pkg::*;

  localparam int SYM_W      = 4;
  localparam int CREDIT_W   = 8;
  localparam int MAX_CREDIT = 99;
  localparam int BET        = 1;
  localparam int AUTO_STOP  = 8;
  localparam int PAY_TRIPLE = 10;
  localparam int PAY_PAIR   = 2;

  logic                clk_2 = 1'b0;
  logic                reset_n = 1'b0;
  logic                coin = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [SYM_W-1:0]    reel0 = '0;
  logic [SYM_W-1:0]    reel1 = '0;
  logic [SYM_W-1:0]    reel2 = '0;
  logic [2:0]          freeze;
  logic                reels_clear;
  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W-1:0] payout;
  logic                win;
  logic [2:0]          state;

  slot_sequencer #(
    .SYM_W(SYM_W), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .BET(BET),
    .AUTO_STOP(AUTO_STOP), .PAY_TRIPLE(PAY_TRIPLE), .PAY_PAIR(PAY_PAIR)
  ) dut (
    .clk_2(clk_2), .reset_n(reset_n), .coin(coin), .start(start), .stop(stop),
    .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .freeze(freeze), .reels_clear(reels_clear), .credits(credits),
    .payout(payout), .win(win), .state(state)
  );

  always #5 clk_2 = ~clk_2;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: phase 0 idle, 1..3 reel (phase-1) spinning, 4 scoring, 5 paying.
  int         m_phase, m_cnt, m_credits, m_payout;
  logic [2:0] m_freeze;
  logic       m_clear, m_win;
  logic       p_coin, p_start, p_stop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int score_of(input int a, input int b, input int c);
    int distinct;
    distinct = 1;
    if (b != a) distinct++;
    if (c != a && c != b) distinct++;
    if (distinct == 1) return PAY_TRIPLE;
    if (distinct == 2) return PAY_PAIR;
    return 0;
  endfunction

  function automatic slot_state_t phase_state(input int ph);
    case (ph)
      1:       return ST_SPIN0;
      2:       return ST_SPIN1;
      3:       return ST_SPIN2;
      4:       return ST_EVAL;
      5:       return ST_PAY;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_credits = 0; m_payout = 0;
    m_freeze = 3'b111; m_clear = 1'b0; m_win = 1'b0;
    p_coin = 1'b1; p_start = 1'b1; p_stop = 1'b1;
  endtask

  task automatic model_step();
    bit ce, se, te;
    int delta;
    ce = coin && !p_coin;
    se = start && !p_start;
    te = stop && !p_stop;
    p_coin = coin; p_start = start; p_stop = stop;
    delta = ce ? 1 : 0;
    m_clear = 1'b0;
    case (m_phase)
      0: if (se && m_credits >= BET) begin
        delta -= BET;
        m_phase = 1; m_cnt = 0;
        m_freeze = 3'b000; m_clear = 1'b1; m_win = 1'b0;
      end
      1, 2, 3: if (te || m_cnt == AUTO_STOP - 1) begin
        m_freeze[m_phase-1] = 1'b1;
        m_phase++;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      4: begin
        m_payout = score_of(int'(reel0), int'(reel1), int'(reel2));
        m_phase = 5;
      end
      default: begin
        delta += m_payout;
        m_win = (m_payout != 0);
        m_phase = 0;
      end
    endcase
    m_credits += delta;
    if (m_credits > MAX_CREDIT) m_credits = MAX_CREDIT;
  endtask

  task automatic compare_all();
    chk("state",       32'(state),       32'(phase_state(m_phase)));
    chk("freeze",      32'(freeze),      32'(m_freeze));
    chk("reels_clear", 32'(reels_clear), 32'(m_clear));
    chk("credits",     32'(credits),     32'(m_credits));
    chk("payout",      32'(payout),      32'(m_payout));
    chk("win",         32'(win),         32'(m_win));
  endtask

  // Inputs change only between negedge and posedge; outputs sampled at negedge.
  task automatic tick();
    @(posedge clk_2);
    if (reset_n) model_step();
    else         model_reset();
    @(negedge clk_2);
    compare_all();
  endtask

  task automatic coin_pulse();
    coin = 1'b1; tick();
    coin = 1'b0; tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic play_game(input int a, input int b, input int c, input bit use_stop);
    reel0 = 4'(a); reel1 = 4'(b); reel2 = 4'(c);
    start = 1'b1; tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 80 && state != ST_IDLE; i++) begin
      if (use_stop) stop = ~stop;
      tick();
    end
    stop = 1'b0;
    chk("game_end", 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    logic [2:0] fz_exp [3];
    fz_exp = '{3'b001, 3'b011, 3'b111};
    model_reset();

    // Reset held over a few edges, then released.
    @(negedge clk_2);
    tick();
    tick();
    chk("rst_freeze",  32'(freeze),  32'd7);
    chk("rst_credits", 32'(credits), 32'd0);
    reset_n = 1'b1;
    tick();

    // Three coins, then start a game on a triple with manual stops.
    for (int i = 0; i < 3; i++) coin_pulse();
    chk("coins3", 32'(credits), 32'd3);
    reel0 = 4'd5; reel1 = 4'd5; reel2 = 4'd5;
    start = 1'b1; tick();
    chk("start_credits", 32'(credits),     32'd2);
    chk("start_freeze",  32'(freeze),      32'd0);
    chk("start_clear",   32'(reels_clear), 32'd1);
    start = 1'b0; tick();
    chk("clear_drop",    32'(reels_clear), 32'd0);
    for (int k = 0; k < 3; k++) begin
      stop = 1'b1; tick();
      chk("stop_freeze", 32'(freeze), 32'(fz_exp[k]));
      stop = 1'b0; tick();
    end
    chk("triple_payout", 32'(payout), 32'd10);
    tick();
    chk("triple_credits", 32'(credits), 32'd12);
    chk("triple_win",     32'(win),     32'd1);

    // Drain credits on losing games, then try to start with none.
    for (int g = 0; g < 20 && m_credits > 0; g++) play_game(0, 1, 2, 1'b1);
    chk("drained", 32'(credits), 32'd0);
    start = 1'b1; tick();
    chk("nocredit_state",  32'(state),  32'(ST_IDLE));
    chk("nocredit_freeze", 32'(freeze), 32'd7);
    start = 1'b0; tick();

    // One credit, coin and start together, then let auto-stop run the reels.
    coin_pulse();
    reel0 = 4'd2; reel1 = 4'd3; reel2 = 4'd2;
    coin = 1'b1; start = 1'b1; tick();
    chk("coinstart_credits", 32'(credits), 32'd1);
    chk("coinstart_state",   32'(state),   32'(ST_SPIN0));
    coin = 1'b0; start = 1'b0;
    for (int i = 1; i <= 3 * AUTO_STOP; i++) begin
      tick();
      if (i % AUTO_STOP == 0) chk("auto_freeze", 32'(freeze), 32'(fz_exp[i/AUTO_STOP-1]));
    end
    tick();
    chk("pair_payout", 32'(payout), 32'd2);
    tick();
    chk("pair_credits", 32'(credits), 32'd3);

    // Fill to the ceiling, then a triple and a coin must both saturate.
    for (int i = 0; i < 120 && m_credits < MAX_CREDIT; i++) coin_pulse();
    chk("full", 32'(credits), 32'd99);
    play_game(4, 4, 4, 1'b1);
    chk("sat_triple", 32'(credits), 32'd99);
    coin_pulse();
    chk("sat_coin", 32'(credits), 32'd99);

    // Asynchronous reset in the middle of SPIN1, with switches held across release.
    start = 1'b1; tick();
    start = 1'b0; tick();
    stop  = 1'b1; tick();
    stop  = 1'b0; tick();
    chk("in_spin1", 32'(state), 32'(ST_SPIN1));
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_freeze",  32'(freeze),  32'd7);
    chk("async_credits", 32'(credits), 32'd0);
    chk("async_state",   32'(state),   32'(ST_IDLE));
    coin = 1'b1; start = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("held_state",   32'(state),   32'(ST_IDLE));
    chk("held_credits", 32'(credits), 32'd0);
    coin = 1'b0; start = 1'b0; tick();

    // Random switch activity with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      coin  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 4) == 0);
      reel0 = 4'($urandom_range(0, 2));
      reel1 = 4'($urandom_range(0, 2));
      reel2 = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) apply_reset();
      else                             tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/slot_sequencer.md
# slot_sequencer

Game controller for the three-reel slot machine on the FPGA board. It owns the credit balance, detects edges on the coin/start/stop switches, and sequences the reel counters. It clears and releases the reels, then freezes them one at a time on a stop press or an auto-stop timeout. Once all three are frozen, it scores the frozen symbols and pays out credits. It drives the `freeze[2:0]` and `reels_clear` controls that the reel-counter datapath consumes, and reads the counter values back.

## Interface
Parameters:
- `SYM_W`, 4: reel symbol width (symbols 0..6).
- `CREDIT_W`, 8: credit register width.
- `MAX_CREDIT`, 99: credit saturation value.
- `BET`, 1: credits charged per game.
- `AUTO_STOP`, 8: cycles a reel spins before it is forced to stop.
- `PAY_TRIPLE`, 10: payout when all three symbols are equal.
- `PAY_PAIR`, 2: payout when exactly two symbols are equal.

Ports:
- `clk_2` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `coin` in 1: level switch; each rising edge inserts one credit.
- `start` in 1: level switch; a rising edge starts a game.
- `stop` in 1: level switch; a rising edge stops the current reel.
- `reel0`, `reel1`, `reel2` in SYM_W: current reel counter values.
- `freeze` out 3: bit k=1 holds reel k.
- `reels_clear` out 1: one-cycle pulse that zeroes the reel counters.
- `credits` out CREDIT_W: current balance.
- `payout` out CREDIT_W: payout of the last game.
- `win` out 1: last game paid a nonzero amount.
- `state` out 3: FSM state encoding, for the LEDs.

## Operation
- Edge detection:
  - Edge = input & ~input_q. It acts in the same cycle as the rise.
  - The `_q` registers reset to 1, so a switch held high through reset produces no edge.
- FSM states: IDLE, SPIN0, SPIN1, SPIN2, EVAL, PAY.
- IDLE:
  - A start edge with credits >= BET goes to SPIN0. Credits -= BET, freeze=000, reels_clear=1, win=0.
  - A start edge with credits < BET is ignored. The check uses credits before any same-cycle coin.
- SPINk (k=0..2):
  - A stop edge, or timer == AUTO_STOP-1, sets freeze[k].
  - The FSM then moves to SPIN(k+1), or to EVAL from SPIN2.
  - The timer clears on every state change and counts only in SPINk.
- EVAL (one cycle): payout is registered as follows.
  - reel0==reel1==reel2 gives PAY_TRIPLE.
  - Any single equal pair gives PAY_PAIR.
  - Otherwise 0.
- PAY (one cycle): credits += payout, saturating at MAX_CREDIT. win = (payout != 0). The FSM then returns to IDLE.
- Coin edges are accepted in every state: credits += 1, saturating.
- Simultaneous credit events:
  - Coin with start: the net change is +1 - BET.
  - Coin in PAY: the net change is +1 + payout.
  - Saturation is applied after the sum.
- Ignored edges:
  - Start outside IDLE.
  - Stop in IDLE, EVAL or PAY.
- freeze stays 111 in IDLE, so the last result remains displayed.
- Reset values (immediately on reset_n low, in any state):
  - State IDLE, freeze=111, reels_clear=0.
  - credits=0, payout=0, win=0, timer=0.

## Timing
- All outputs are registered.
- Start edge at cycle T: at T+1, state=SPIN0, freeze=000, reels_clear=1 (low again at T+2), credits decremented.
- Stop edge at cycle T in SPINk: freeze[k]=1 at T+1.
- Auto-stop: freeze[k] rises AUTO_STOP cycles after SPINk is entered.
- Final stop at cycle T: EVAL at T+1, payout valid at T+2 (PAY), credits and win updated and state=IDLE at T+3.
- Reels are sampled in EVAL, when freeze=111, so the values are stable.
- Timer width is $clog2(AUTO_STOP).

## Structure
- Package `slot_pkg`: state enum `slot_state_t` (3-bit), payout constants, and the `sat_add` function.
- Sub-module `edge_detect` (with an asynchronous active-low reset), instantiated three times for coin, start and stop.
- The scoring comparator is combinational inside the block.

## Test plan
- Reset, then three coin edges → credits=3. A start edge → credits=2, freeze=000, reels_clear high for exactly 1 cycle.
- Reels held at 5,5,5, three stop edges → freeze 001→011→111, payout=10, credits=12, win=1 three cycles after the last stop.
- Credits=0, start edge → state stays IDLE, freeze stays 111. Credits=1 with coin+start in the same cycle → game starts, credits=1.
- No stop edges → freeze=001 at 8, 011 at 16 and 111 at 24 cycles after SPIN0 is entered. Reels 2,3,2 → payout=2.
- Credits=98 with a triple → credits=99, saturated. A coin edge at 99 → stays 99.
- reset_n low during SPIN1 → immediately freeze=111, credits=0, state=IDLE. start held high across reset release → no game starts.
